reflet_timer: RTL and testbench

REFLET_TIMER -- requirements
Module: reflet_timer

---
 rtl/reflet_timer_pkg.sv | 39 +++
 rtl/reflet_timer_prescaler.sv | 39 +++
 rtl/reflet_timer.sv | 149 ++++++++++++++
 tb/tb_reflet_timer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reflet_timer_pkg.sv
// Shared register map and CTRL/STATUS bit positions for the reflet timer.
// Software-facing documentation uses the same numbering.
package reflet_timer_pkg;

    localparam int unsigned REG_CTRL     = 0;
    localparam int unsigned REG_PRESCALE = 1;
    localparam int unsigned REG_RELOAD   = 2;
    localparam int unsigned REG_COUNT    = 3;
    localparam int unsigned REG_STATUS   = 4;
    localparam int unsigned NUM_REGS     = 5;

    localparam int unsigned CTRL_RUN        = 0;
    localparam int unsigned CTRL_AUTORELOAD = 1;
    localparam int unsigned CTRL_IRQ_EN     = 2;
    localparam int unsigned CTRL_BITS       = 3;

    localparam int unsigned STATUS_PENDING = 0;

    typedef enum logic [2:0] {
        SEL_CTRL     = 3'd0,
        SEL_PRESCALE = 3'd1,
        SEL_RELOAD   = 3'd2,
        SEL_COUNT    = 3'd3,
        SEL_STATUS   = 3'd4
    } reg_sel_e;

    typedef struct packed {
        logic irq_en;
        logic autoreload;
        logic run;
    } ctrl_t;

    function automatic logic [63:0] reg_addr(input logic [63:0] base,
                                             input int unsigned k,
                                             input int unsigned bytes);
        return base + 64'(k * bytes);
    endfunction

endpackage

// File: rtl/reflet_timer_prescaler.sv
// Free-running prescaler: counts 0..limit and emits one tick as it wraps.
// clear has priority so a stopped timer always restarts from a fresh period.
module reflet_prescaler #(
    parameter int unsigned width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [width-1:0] limit,
    output logic             tick
);

    localparam logic [width-1:0] ONE = {{(width-1){1'b0}}, 1'b1};

    logic [width-1:0] cnt_q, cnt_d;
    logic             at_limit;

    assign at_limit = (cnt_q == limit);
    assign tick     = enable & at_limit;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = at_limit ? '0 : cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reflet_timer.sv
// Memory-mapped down-counting timer: register file, address decode,
// COUNT/expiry logic and the level interrupt. Prescaler is a sub-module.
module reflet_timer
    import reflet_timer_pkg::*;
#(
    parameter int unsigned wordsize  = 16,
    parameter logic [63:0] base_addr = 64'hFF00
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [wordsize-1:0] addr,
    input  logic [wordsize-1:0] data_in,
    input  logic                write_en,
    output logic [wordsize-1:0] data_out,
    output logic                interrupt
);

    localparam int unsigned      BYTES = wordsize / 8;
    localparam logic [wordsize-1:0] ONE = {{(wordsize-1){1'b0}}, 1'b1};

    ctrl_t               ctrl_q, ctrl_d;
    logic [wordsize-1:0] prescale_q, prescale_d;
    logic [wordsize-1:0] reload_q, reload_d;
    logic [wordsize-1:0] count_q, count_d;
    logic                pending_q, pending_d;
    logic                interrupt_q, interrupt_d;
    logic [wordsize-1:0] data_out_q, data_out_d;

    logic     sel;
    reg_sel_e sel_idx;
    logic     wr_ctrl, wr_prescale, wr_reload, wr_count, wr_status;
    logic     tick, expiry, presc_clear;

    // Exact-match decode: misaligned or out-of-range addresses select nothing.
    always_comb begin
        sel     = 1'b0;
        sel_idx = SEL_CTRL;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (addr == wordsize'(reg_addr(base_addr, k, BYTES))) begin
                sel     = 1'b1;
                sel_idx = reg_sel_e'(k[2:0]);
            end
        end
    end

    assign wr_ctrl     = write_en & sel & (sel_idx == SEL_CTRL);
    assign wr_prescale = write_en & sel & (sel_idx == SEL_PRESCALE);
    assign wr_reload   = write_en & sel & (sel_idx == SEL_RELOAD);
    assign wr_count    = write_en & sel & (sel_idx == SEL_COUNT);
    assign wr_status   = write_en & sel & (sel_idx == SEL_STATUS);

    // Prescaler restarts on the same edge that software stops the timer.
    assign presc_clear = ~ctrl_q.run | (wr_ctrl & ~data_in[CTRL_RUN]);

    reflet_prescaler #(
        .width (wordsize)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (ctrl_q.run & enable),
        .clear  (presc_clear),
        .limit  (prescale_q),
        .tick   (tick)
    );

    assign expiry = tick & (count_q == '0);

    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        reload_d   = reload_q;
        count_d    = count_q;
        pending_d  = pending_q;

        if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - ONE;
            end else if (ctrl_q.autoreload) begin
                count_d = reload_q;
            end else begin
                ctrl_d.run = 1'b0;
            end
        end

        // Bus writes are applied after the counter so they win collisions.
        if (wr_ctrl) begin
            ctrl_d = ctrl_t'(data_in[CTRL_BITS-1:0]);
        end
        if (wr_prescale) begin
            prescale_d = data_in;
        end
        if (wr_reload) begin
            reload_d = data_in;
        end
        if (wr_count) begin
            count_d = data_in;
        end
        if (wr_status && data_in[STATUS_PENDING]) begin
            pending_d = 1'b0;
        end

        // An expiry beats a simultaneous software clear.
        if (expiry) begin
            pending_d = 1'b1;
        end
    end

    assign interrupt_d = pending_d & ctrl_d.irq_en;

    // Read data reflects pre-write register contents.
    always_comb begin
        data_out_d = '0;
        if (sel) begin
            case (sel_idx)
                SEL_CTRL:     data_out_d = {{(wordsize-CTRL_BITS){1'b0}}, ctrl_q};
                SEL_PRESCALE: data_out_d = prescale_q;
                SEL_RELOAD:   data_out_d = reload_q;
                SEL_COUNT:    data_out_d = count_q;
                SEL_STATUS:   data_out_d = {{(wordsize-1){1'b0}}, pending_q};
                default:      data_out_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q      <= '0;
            prescale_q  <= '0;
            reload_q    <= '0;
            count_q     <= '0;
            pending_q   <= 1'b0;
            interrupt_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            prescale_q  <= prescale_d;
            reload_q    <= reload_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            interrupt_q <= interrupt_d;
            data_out_q  <= data_out_d;
        end
    end

    assign data_out  = data_out_q;
    assign interrupt = interrupt_q;

endmodule

// File: tb/tb_reflet_timer.sv
// Scenario bench for reflet_timer: bus reads push expected data to a queue
// that is popped and compared one cycle later when data_out is valid.
module tb_reflet_timer;

    localparam logic [15:0] BASE      = 16'hFF00;
    localparam logic [15:0] IDLE_ADDR = 16'h0100;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        enable   = 1'b1;
    logic        write_en = 1'b0;
    logic [15:0] addr     = IDLE_ADDR;
    logic [15:0] data_in  = '0;
    logic [15:0] data_out;
    logic        interrupt;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    reflet_timer #(
        .wordsize  (16),
        .base_addr (64'hFF00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .addr      (addr),
        .data_in   (data_in),
        .write_en  (write_en),
        .data_out  (data_out),
        .interrupt (interrupt)
    );

    function automatic logic [15:0] ra(input int k);
        return BASE + 16'(k * 2);
    endfunction

    // One bus cycle; a checked read is scored against data_out after the edge.
    task automatic bus(input logic [15:0] a, input logic [15:0] wd, input logic we,
                       input logic chk, input logic [15:0] exp, input string tag);
        logic [15:0] want;
        string       name;
        addr     = a;
        data_in  = wd;
        write_en = we;
        if (chk) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
        @(posedge clk);
        #1;
        write_en = 1'b0;
        addr     = IDLE_ADDR;
        data_in  = '0;
        if (chk) begin
            want = exp_q.pop_front();
            name = tag_q.pop_front();
            checks++;
            if (data_out !== want) begin
                errors++;
                $display("FAIL %s: data_out=%h expected=%h", name, data_out, want);
            end
        end
    endtask

    task automatic idle_bus();
        bus(IDLE_ADDR, 16'h0, 1'b0, 1'b0, 16'h0, "");
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (data_out !== 16'h0 || interrupt !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: data_out=%h interrupt=%b expected 0/0", data_out, interrupt);
        end
        reset = 1'b1;
        for (int k = 0; k < 5; k++) bus(ra(k), 16'h0, 1'b0, 1'b1, 16'h0, "reset_read");
        checks++;
        if (interrupt !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: interrupt=%b expected 0", interrupt);
        end
    endtask

    task automatic test_one_shot();
        bus(ra(1), 16'd0, 1'b1, 1'b0, 16'h0, "");
        bus(ra(3), 16'd3, 1'b1, 1'b0, 16'h0, "");
        bus(ra(0), 16'h5, 1'b1, 1'b0, 16'h0, "");
        for (int i = 1; i <= 4; i++) begin
            idle_bus();
            checks++;
            if (interrupt !== (i == 4)) begin
                errors++;
                $display("FAIL oneshot_irq cycle %0d: interrupt=%b expected %b", i, interrupt, (i == 4));
            end
        end
        bus(ra(0), 16'h0, 1'b0, 1'b1, 16'h4, "oneshot_ctrl");
        bus(ra(3), 16'h0, 1'b0, 1'b1, 16'h0, "oneshot_count");
        bus(ra(4), 16'h0, 1'b0, 1'b1, 16'h1, "oneshot_status");
        bus(ra(4), 16'h1, 1'b1, 1'b0, 16'h0, "");
        checks++;
        if (interrupt !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_clear: interrupt=%b expected 0", interrupt);
        end
    endtask

    task automatic test_autoreload();
        logic pend;
        logic clr;
        bus(ra(1), 16'd2, 1'b1, 1'b0, 16'h0, "");
        bus(ra(2), 16'd1, 1'b1, 1'b0, 16'h0, "");
        bus(ra(3), 16'd1, 1'b1, 1'b0, 16'h0, "");
        bus(ra(0), 16'h7, 1'b1, 1'b0, 16'h0, "");
        pend = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            clr = (i == 8) || (i == 14);
            bus(clr ? ra(4) : IDLE_ADDR, 16'h1, clr, 1'b0, 16'h0, "");
            if (i % 6 == 0) pend = 1'b1;
            else if (clr) pend = 1'b0;
            checks++;
            if (interrupt !== pend) begin
                errors++;
                $display("FAIL autoreload_irq cycle %0d: interrupt=%b expected %b", i, interrupt, pend);
            end
        end
        bus(ra(0), 16'h0, 1'b1, 1'b0, 16'h0, "");
        bus(ra(4), 16'h1, 1'b1, 1'b0, 16'h0, "");
        checks++;
        if (interrupt !== 1'b0) begin
            errors++;
            $display("FAIL autoreload_stop: interrupt=%b expected 0", interrupt);
        end
    endtask

    task automatic test_collision();
        bus(ra(1), 16'd0, 1'b1, 1'b0, 16'h0, "");
        bus(ra(2), 16'd9, 1'b1, 1'b0, 16'h0, "");
        bus(ra(3), 16'd2, 1'b1, 1'b0, 16'h0, "");
        bus(ra(0), 16'h3, 1'b1, 1'b0, 16'h0, "");
        idle_bus();
        idle_bus();
        bus(ra(4), 16'h1, 1'b1, 1'b0, 16'h0, "");
        bus(ra(4), 16'h0, 1'b0, 1'b1, 16'h1, "coll_status_set_wins");
        checks++;
        if (interrupt !== 1'b0) begin
            errors++;
            $display("FAIL coll_irq_masked: interrupt=%b expected 0", interrupt);
        end
        bus(ra(0), 16'h0, 1'b1, 1'b0, 16'h0, "");
        bus(ra(4), 16'h1, 1'b1, 1'b0, 16'h0, "");
        // COUNT write on the expiry edge
        bus(ra(3), 16'd1, 1'b1, 1'b0, 16'h0, "");
        bus(ra(0), 16'h3, 1'b1, 1'b0, 16'h0, "");
        idle_bus();
        bus(ra(3), 16'd7, 1'b1, 1'b0, 16'h0, "");
        bus(ra(3), 16'h0, 1'b0, 1'b1, 16'd7, "coll_count_write_wins");
        bus(ra(4), 16'h0, 1'b0, 1'b1, 16'h1, "coll_count_pending");
        bus(ra(0), 16'h0, 1'b1, 1'b0, 16'h0, "");
        bus(ra(4), 16'h1, 1'b1, 1'b0, 16'h0, "");
        // CTRL write clearing run on the expiry edge
        bus(ra(3), 16'd1, 1'b1, 1'b0, 16'h0, "");
        bus(ra(0), 16'h3, 1'b1, 1'b0, 16'h0, "");
        idle_bus();
        bus(ra(0), 16'h2, 1'b1, 1'b0, 16'h0, "");
        bus(ra(0), 16'h0, 1'b0, 1'b1, 16'h2, "coll_ctrl_write_wins");
        bus(ra(4), 16'h0, 1'b0, 1'b1, 16'h1, "coll_ctrl_pending");
        bus(ra(4), 16'h1, 1'b1, 1'b0, 16'h0, "");
    endtask

    task automatic test_freeze_decode();
        bus(ra(3), 16'd10, 1'b1, 1'b0, 16'h0, "");
        bus(ra(0), 16'h1, 1'b1, 1'b0, 16'h0, "");
        idle_bus();
        idle_bus();
        enable = 1'b0;
        repeat (10) idle_bus();
        bus(ra(3), 16'h0, 1'b0, 1'b1, 16'd8, "freeze_count_held");
        enable = 1'b1;
        idle_bus();
        bus(ra(3), 16'h0, 1'b0, 1'b1, 16'd7, "freeze_resumed");
        bus(ra(0), 16'h0, 1'b1, 1'b0, 16'h0, "");
        bus(ra(3), 16'h1234, 1'b1, 1'b0, 16'h0, "");
        bus(ra(5), 16'hBEEF, 1'b1, 1'b1, 16'h0, "decode_k5_zero");
        bus(BASE + 16'd1, 16'hBEEF, 1'b1, 1'b1, 16'h0, "decode_misaligned_zero");
        bus(ra(0), 16'h0, 1'b0, 1'b1, 16'h0, "decode_ctrl");
        bus(ra(1), 16'h0, 1'b0, 1'b1, 16'h0, "decode_prescale");
        bus(ra(2), 16'h0, 1'b0, 1'b1, 16'd9, "decode_reload");
        bus(ra(3), 16'h0, 1'b0, 1'b1, 16'h1234, "decode_count");
        bus(ra(4), 16'h0, 1'b0, 1'b1, 16'h0, "decode_status");
    endtask

    task automatic test_async_reset();
        bus(ra(2), 16'd6, 1'b1, 1'b0, 16'h0, "");
        bus(ra(3), 16'd0, 1'b1, 1'b0, 16'h0, "");
        bus(ra(0), 16'h7, 1'b1, 1'b0, 16'h0, "");
        idle_bus();
        checks++;
        if (interrupt !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre_irq: interrupt=%b expected 1", interrupt);
        end
        bus(ra(0), 16'h0, 1'b0, 1'b1, 16'h7, "areset_pre_ctrl");
        #3 reset = 1'b0;
        #1;
        checks++;
        if (data_out !== 16'h0 || interrupt !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: data_out=%h interrupt=%b expected 0/0", data_out, interrupt);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) idle_bus();
        checks++;
        if (interrupt !== 1'b0) begin
            errors++;
            $display("FAIL areset_idle_irq: interrupt=%b expected 0", interrupt);
        end
        for (int k = 0; k < 5; k++) bus(ra(k), 16'h0, 1'b0, 1'b1, 16'h0, "areset_read");
        repeat (4) idle_bus();
        bus(ra(3), 16'h0, 1'b0, 1'b1, 16'h0, "areset_stays_idle");
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_autoreload();
        test_collision();
        test_freeze_decode();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: left=%0d expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
